apb_sram_ctrl: RTL and testbench

APB slave that converts single APB transfers into timed read/write cycles on a 16-bit asynchronous SRAM. It drives the SRAM pin bundle (address, chip/output/write enables, byte lanes, split write/read data with a tristate enable) that the board-level SRAM model consumes. Every access is a fixed-length, fully registered pin sequence; there is no buffering, so exactly one APB transfer is outstanding at a time.

---
 rtl/apb_sram_ctrl.sv | 149 ++++++++++++++
 tb/tb_apb_sram_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/apb_sram_ctrl.sv
// APB slave driving a 16-bit asynchronous SRAM with fixed-length, fully registered
// setup / strobe / recover pin sequences; one transfer in flight at a time.
module apb_sram_ctrl #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_WIDTH  = 16
) (
  input  logic                  PCLK,
  input  logic                  SYSRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [31:0]           PADDR,
  input  logic [31:0]           PWDATA,
  input  logic [1:0]            PSTRB,
  output logic [31:0]           PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic [ADDR_WIDTH-1:0] io_address,
  output logic                  io_ce,
  output logic                  io_we,
  output logic                  io_oe,
  output logic                  io_ub,
  output logic                  io_lb,
  output logic [15:0]           io_data_write,
  output logic                  io_data_writeEnable,
  input  logic [15:0]           io_data_read
);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, RECOVER, RESP} state_t;

  state_t                r_state, w_next;
  logic [3:0]            r_cnt;
  logic                  r_write;
  logic [15:0]           r_rdata;
  logic                  w_start, w_bad;
  logic                  w_ce, w_we, w_oe, w_ub, w_lb, w_de, w_ready, w_slverr;
  logic [31:0]           w_prdata;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [15:0]           w_wdata;
  logic                  w_unused;

  assign w_start  = (r_state == IDLE) && PSEL && !PENABLE;
  assign w_bad    = |PADDR[31:ADDR_WIDTH+1];
  assign w_unused = ^{PWDATA[31:16], PADDR[0]};

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = w_bad ? RESP : SETUP;
      SETUP:   w_next = PULSE;
      PULSE:   if (r_cnt == 4'd0) w_next = RECOVER;
      RECOVER: w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Pin values are decoded from the state being entered so every output is a flop.
  always_comb begin
    w_ce     = io_ce;
    w_we     = 1'b1;
    w_oe     = 1'b1;
    w_ub     = io_ub;
    w_lb     = io_lb;
    w_de     = io_data_writeEnable;
    w_addr   = io_address;
    w_wdata  = io_data_write;
    w_ready  = 1'b0;
    w_slverr = 1'b0;
    w_prdata = 32'h0;
    case (w_next)
      IDLE: begin
        w_ce = 1'b1;
        w_ub = 1'b1;
        w_lb = 1'b1;
        w_de = 1'b0;
      end
      SETUP: begin
        w_ce   = 1'b0;
        w_addr = PADDR[ADDR_WIDTH:1];
        if (PWRITE) begin
          w_wdata = PWDATA[15:0];
          w_de    = 1'b1;
          w_ub    = ~PSTRB[1];
          w_lb    = ~PSTRB[0];
        end else begin
          w_de = 1'b0;
          w_ub = 1'b0;
          w_lb = 1'b0;
        end
      end
      PULSE: begin
        w_we = ~r_write;
        w_oe = r_write;
      end
      RESP: begin
        w_ce    = 1'b1;
        w_ub    = 1'b1;
        w_lb    = 1'b1;
        w_de    = 1'b0;
        w_ready = 1'b1;
        // RESP is entered straight from IDLE only on an address error.
        w_slverr = (r_state == IDLE);
        if (r_state == RECOVER && !r_write) w_prdata = {16'h0, r_rdata};
      end
      default: ;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (SYSRESET) begin
      r_state             <= IDLE;
      r_cnt               <= 4'd0;
      r_write             <= 1'b0;
      r_rdata             <= 16'h0;
      io_ce               <= 1'b1;
      io_we               <= 1'b1;
      io_oe               <= 1'b1;
      io_ub               <= 1'b1;
      io_lb               <= 1'b1;
      io_data_writeEnable <= 1'b0;
      io_address          <= '0;
      io_data_write       <= 16'h0;
      PREADY              <= 1'b0;
      PSLVERR             <= 1'b0;
      PRDATA              <= 32'h0;
    end else begin
      r_state <= w_next;
      if (w_start && !w_bad) r_write <= PWRITE;
      if (r_state == SETUP)
        r_cnt <= 4'(WAIT_CYCLES);
      else if (r_state == PULSE && r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;
      if (r_state == PULSE && r_cnt == 4'd0 && !r_write) r_rdata <= io_data_read;
      io_ce               <= w_ce;
      io_we               <= w_we;
      io_oe               <= w_oe;
      io_ub               <= w_ub;
      io_lb               <= w_lb;
      io_data_writeEnable <= w_de;
      io_address          <= w_addr;
      io_data_write       <= w_wdata;
      PREADY              <= w_ready;
      PSLVERR             <= w_slverr;
      PRDATA              <= w_prdata;
    end
  end

endmodule

// File: tb/tb_apb_sram_ctrl.sv
// Directed bench: a W=2 and a W=0 controller, each with its own SRAM model, checked
// cycle-by-cycle through per-cycle pin masks (bit c = condition true in cycle c).
module tb_apb_sram_ctrl;
  logic        PCLK = 1'b0;
  logic        SYSRESET = 1'b1;
  logic        PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PADDR = 32'h0, PWDATA = 32'h0;
  logic [1:0]  PSTRB = 2'b00;
  logic        psel [2];
  logic [31:0] prdata [2];
  logic        pready [2], pslverr [2];
  logic [15:0] addr [2], dw [2], dr [2];
  logic        ce [2], we [2], oe [2], ub [2], lb [2], de [2];

  int n_chk = 0, n_fail = 0;
  logic [15:0] m_ce, m_we, m_oe, m_de, m_ub, m_lb, m_rdy, a1, d1;
  logic [31:0] r_data;
  logic        r_err;
  int          stray;

  always #15 PCLK = ~PCLK;

  apb_sram_ctrl #(.WAIT_CYCLES(2), .ADDR_WIDTH(16)) u_dut_w2 (
    .PCLK(PCLK), .SYSRESET(SYSRESET), .PSEL(psel[0]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(prdata[0]), .PREADY(pready[0]),
    .PSLVERR(pslverr[0]), .io_address(addr[0]), .io_ce(ce[0]), .io_we(we[0]), .io_oe(oe[0]),
    .io_ub(ub[0]), .io_lb(lb[0]), .io_data_write(dw[0]), .io_data_writeEnable(de[0]),
    .io_data_read(dr[0]));

  apb_sram_ctrl #(.WAIT_CYCLES(0), .ADDR_WIDTH(16)) u_dut_w0 (
    .PCLK(PCLK), .SYSRESET(SYSRESET), .PSEL(psel[1]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(prdata[1]), .PREADY(pready[1]),
    .PSLVERR(pslverr[1]), .io_address(addr[1]), .io_ce(ce[1]), .io_we(we[1]), .io_oe(oe[1]),
    .io_ub(ub[1]), .io_lb(lb[1]), .io_data_write(dw[1]), .io_data_writeEnable(de[1]),
    .io_data_read(dr[1]));

  for (genvar g = 0; g < 2; g++) begin : g_sram
    logic [15:0] mem [256];
    assign dr[g] = (!ce[g] && !oe[g]) ? mem[addr[g][7:0]] : 16'h0;
    always @(posedge PCLK) begin
      if (!ce[g] && !we[g] && de[g]) begin
        if (!lb[g]) mem[addr[g][7:0]][7:0]  <= dw[g][7:0];
        if (!ub[g]) mem[addr[g][7:0]][15:8] <= dw[g][15:8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Starts at posedge+1 (cycle 0 = setup phase); returns at posedge+1 after RESP.
  task automatic xfer(input int s, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [1:0] st);
    m_ce = '0; m_we = '0; m_oe = '0; m_de = '0; m_ub = '0; m_lb = '0; m_rdy = '0;
    a1 = '0; d1 = '0; r_data = '0; r_err = 1'b0; stray = 0;
    psel[s] = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd; PSTRB = st;
    for (int c = 0; c < 16; c++) begin
      @(negedge PCLK);
      m_ce[c] = !ce[s]; m_we[c] = !we[s]; m_oe[c] = !oe[s]; m_de[c] = de[s];
      m_ub[c] = !ub[s]; m_lb[c] = !lb[s]; m_rdy[c] = pready[s];
      if (c == 1) begin a1 = addr[s]; d1 = dw[s]; end
      if (pready[s]) begin r_data = prdata[s]; r_err = pslverr[s]; end
      else if (prdata[s] != 32'h0 || pslverr[s]) stray++;
      tick();
      PENABLE = 1'b1;
      if (m_rdy[c]) break;
    end
    psel[s] = 1'b0; PENABLE = 1'b0;
  endtask

  function automatic logic [7:0] pins(input int s);
    return {ce[s], we[s], oe[s], ub[s], lb[s], de[s], pready[s], pslverr[s]};
  endfunction

  initial begin
    psel[0] = 1'b0; psel[1] = 1'b0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_pins", {24'h0, pins(0)}, 32'h0000_00F8);
    chk("rst_addr_data", {addr[0], dw[0]}, 32'h0);
    chk("rst_prdata", prdata[0], 32'h0);
    tick();
    SYSRESET = 1'b0;
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge PCLK);
      if (pins(0) != 8'hF8 || addr[0] != 16'h0 || dw[0] != 16'h0) stray++;
    end
    chk("idle_quiet", stray, 0);
    tick();

    xfer(0, 1'b1, 32'h10, 32'h0000_0058, 2'b11);
    chk("wr_ce", m_ce, 16'h003E);
    chk("wr_we", m_we, 16'h001C);
    chk("wr_oe", m_oe, 16'h0000);
    chk("wr_de", m_de, 16'h003E);
    chk("wr_ublb", {m_ub, m_lb}, {16'h003E, 16'h003E});
    chk("wr_rdy", m_rdy, 16'h0040);
    chk("wr_err", r_err, 0);
    chk("wr_addr_data", {a1, d1}, {16'h0008, 16'h0058});

    xfer(0, 1'b0, 32'h10, 32'h0, 2'b00);
    chk("rd_oe", m_oe, 16'h001C);
    chk("rd_we_de", {m_we, m_de}, 32'h0);
    chk("rd_ublb", {m_ub, m_lb}, {16'h003E, 16'h003E});
    chk("rd_rdy", m_rdy, 16'h0040);
    chk("rd_data", r_data, 32'h0000_0058);
    xfer(0, 1'b0, 32'h11, 32'h0, 2'b00);
    chk("rd2_stray", stray, 0);
    chk("rd2_data", r_data, 32'h0000_0058);

    xfer(0, 1'b1, 32'h10, 32'h0000_ABCD, 2'b01);
    chk("bw_ublb", {m_ub, m_lb}, {16'h0000, 16'h003E});
    xfer(0, 1'b0, 32'h10, 32'h0, 2'b00);
    chk("bw_data", r_data, 32'h0000_00CD);
    xfer(0, 1'b1, 32'h10, 32'h0000_1234, 2'b00);
    chk("nb_ublb", {m_ub, m_lb}, 32'h0);
    chk("nb_we_rdy", {m_we, m_rdy}, {16'h001C, 16'h0040});
    xfer(0, 1'b0, 32'h10, 32'h0, 2'b00);
    chk("nb_data", r_data, 32'h0000_00CD);

    xfer(0, 1'b0, 32'h0002_0000, 32'h0, 2'b00);
    chk("err_rdy", m_rdy, 16'h0002);
    chk("err_resp", {r_err, r_data[30:0]}, 32'h8000_0000);
    chk("err_ce", m_ce, 16'h0000);
    xfer(0, 1'b0, 32'h10, 32'h0, 2'b00);
    chk("post_err", {m_rdy, r_data[15:0]}, {16'h0040, 16'h00CD});

    // Abort a write in its second strobe cycle.
    psel[0] = 1'b1; PWRITE = 1'b1; PADDR = 32'h20; PWDATA = 32'h7777; PSTRB = 2'b11;
    tick(); PENABLE = 1'b1;
    tick();
    tick(); SYSRESET = 1'b1;
    tick(); SYSRESET = 1'b0; psel[0] = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    chk("rst_mid_pins", {24'h0, pins(0)}, 32'h0000_00F8);
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge PCLK);
      if (pready[0] || !ce[0]) stray++;
    end
    chk("rst_mid_no_rdy", stray, 0);
    tick();

    xfer(1, 1'b1, 32'h4, 32'h0000_55AA, 2'b11);
    chk("w0_wr_rdy", m_rdy, 16'h0010);
    chk("w0_wr_ce_we", {m_ce, m_we}, {16'h000E, 16'h0004});
    xfer(1, 1'b0, 32'h4, 32'h0, 2'b00);
    chk("w0_rd_rdy", m_rdy, 16'h0010);
    chk("w0_rd_oe", m_oe, 16'h0004);
    chk("w0_rd_data", r_data, 32'h0000_55AA);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
